// File: rtl/uart_cmd_parser.sv
// ============================================================================
// uart_cmd_parser: locks onto SYNC_BYTE, assembles ADDR/DHI/DLO/CSUM, XOR-checks.
// Optional inter-byte idle timeout: define UART_CMD_TIMEOUT_EN.   Rev 1.0
// ============================================================================
`default_nettype none

`ifndef UART_DATA_LENGTH
`define UART_DATA_LENGTH 8
`endif

module uart_cmd_parser #(
    parameter int                     DATA_LENGTH    = `UART_DATA_LENGTH,
    parameter logic [DATA_LENGTH-1:0] SYNC_BYTE      = DATA_LENGTH'(8'hA5),
    parameter int                     TIMEOUT_CYCLES = 65536
) (
    input  logic                       clk_i,
    input  logic                       rst_n_i,
    input  logic [DATA_LENGTH-1:0]     rx_i,
    input  logic                       rx_i_v,
    output logic [DATA_LENGTH-1:0]     addr_o,
    output logic [2*DATA_LENGTH-1:0]   data_o,
    output logic                       data_o_v,
    output logic                       err_o
);

    typedef enum logic [2:0] {
        ST_SYNC = 3'd0,
        ST_ADDR = 3'd1,
        ST_DHI  = 3'd2,
        ST_DLO  = 3'd3,
        ST_CSUM = 3'd4
    } state_t;

    state_t                 state, state_nxt;
    logic [DATA_LENGTH-1:0] addr_sh, dhi_sh, dlo_sh, acc;
    logic [DATA_LENGTH-1:0] addr_sh_nxt, dhi_sh_nxt, dlo_sh_nxt, acc_nxt;
    logic                   valid_nxt, err_nxt;
    logic                   timeout_hit;

    if (TIMEOUT_CYCLES < 2) begin : g_bad_timeout
        $error("uart_cmd_parser: TIMEOUT_CYCLES must be at least 2");
    end

`ifdef UART_CMD_TIMEOUT_EN
    localparam int               CNT_W    = $clog2(TIMEOUT_CYCLES);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

    logic [CNT_W-1:0] idle_cnt;

    // A strobe on the expiry cycle takes priority over the abort.
    assign timeout_hit = (state != ST_SYNC) && !rx_i_v && (idle_cnt == CNT_LAST);

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            idle_cnt <= '0;
        end else if (rx_i_v || (state == ST_SYNC) || timeout_hit) begin
            idle_cnt <= '0;
        end else begin
            idle_cnt <= idle_cnt + CNT_W'(1);
        end
    end
`else
    assign timeout_hit = 1'b0;
`endif

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            state <= ST_SYNC;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt   = state;
        addr_sh_nxt = addr_sh;
        dhi_sh_nxt  = dhi_sh;
        dlo_sh_nxt  = dlo_sh;
        acc_nxt     = acc;
        valid_nxt   = 1'b0;
        err_nxt     = 1'b0;
        if (rx_i_v) begin
            case (state)
                ST_SYNC: begin
                    if (rx_i == SYNC_BYTE) begin
                        state_nxt = ST_ADDR;
                        acc_nxt   = '0;
                    end
                end
                ST_ADDR: begin
                    addr_sh_nxt = rx_i;
                    acc_nxt     = acc ^ rx_i;
                    state_nxt   = ST_DHI;
                end
                ST_DHI: begin
                    dhi_sh_nxt = rx_i;
                    acc_nxt    = acc ^ rx_i;
                    state_nxt  = ST_DLO;
                end
                ST_DLO: begin
                    dlo_sh_nxt = rx_i;
                    acc_nxt    = acc ^ rx_i;
                    state_nxt  = ST_CSUM;
                end
                ST_CSUM: begin
                    state_nxt = ST_SYNC;
                    if (rx_i == acc) begin
                        valid_nxt = 1'b1;
                    end else begin
                        err_nxt = 1'b1;
                    end
                end
                default: state_nxt = ST_SYNC;
            endcase
        end else if (timeout_hit) begin
            state_nxt = ST_SYNC;
            err_nxt   = 1'b1;
        end
    end

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            addr_sh  <= '0;
            dhi_sh   <= '0;
            dlo_sh   <= '0;
            acc      <= '0;
            addr_o   <= '0;
            data_o   <= '0;
            data_o_v <= 1'b0;
            err_o    <= 1'b0;
        end else begin
            addr_sh  <= addr_sh_nxt;
            dhi_sh   <= dhi_sh_nxt;
            dlo_sh   <= dlo_sh_nxt;
            acc      <= acc_nxt;
            data_o_v <= valid_nxt;
            err_o    <= err_nxt;
            // Shadows already hold the full payload when CSUM arrives.
            if (valid_nxt) begin
                addr_o <= addr_sh;
                data_o <= {dhi_sh, dlo_sh};
            end
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_uart_cmd_parser.sv
// ============================================================================
// tb_uart_cmd_parser: directed + random byte streams against a frame-level model.
// Rev 1.0
// ============================================================================
`default_nettype none

module tb_uart_cmd_parser;

    localparam int TMO = 100;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [7:0]  rx;
    logic        rx_v;
    logic [7:0]  addr;
    logic [15:0] data;
    logic        data_v;
    logic        err;

    int n_vec = 0;
    int n_err = 0;

    // Reference model: byte position in the frame and captured payload.
    int          pos;
    int          idle;
    logic [7:0]  fr [1:3];
    logic        exp_v, exp_err;
    logic [7:0]  exp_addr;
    logic [15:0] exp_data;

    uart_cmd_parser #(
        .DATA_LENGTH    (8),
        .SYNC_BYTE      (8'hA5),
        .TIMEOUT_CYCLES (TMO)
    ) dut (
        .clk_i    (clk),
        .rst_n_i  (rst_n),
        .rx_i     (rx),
        .rx_i_v   (rx_v),
        .addr_o   (addr),
        .data_o   (data),
        .data_o_v (data_v),
        .err_o    (err)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] expv);
        n_vec++;
        if (got !== expv) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, expv, $time);
        end
    endtask

    task automatic model_reset();
        pos      = 0;
        idle     = 0;
        exp_v    = 1'b0;
        exp_err  = 1'b0;
        exp_addr = 8'h00;
        exp_data = 16'h0000;
    endtask

    task automatic model_step(input logic v, input logic [7:0] b);
        exp_v   = 1'b0;
        exp_err = 1'b0;
        if (v) begin
            idle = 0;
            if (pos == 0) begin
                if (b == 8'hA5) pos = 1;
            end else if (pos < 4) begin
                fr[pos] = b;
                pos++;
            end else begin
                if (b == (fr[1] ^ fr[2] ^ fr[3])) begin
                    exp_v    = 1'b1;
                    exp_addr = fr[1];
                    exp_data = {fr[2], fr[3]};
                end else begin
                    exp_err = 1'b1;
                end
                pos = 0;
            end
        end else if (pos != 0) begin
            idle++;
`ifdef UART_CMD_TIMEOUT_EN
            if (idle == TMO) begin
                exp_err = 1'b1;
                pos     = 0;
                idle    = 0;
            end
`endif
        end else begin
            idle = 0;
        end
    endtask

    task automatic step(input logic v, input logic [7:0] b);
        rx_v = v;
        rx   = b;
        model_step(v, b);
        @(posedge clk);
        #1;
        check("data_v", 32'(data_v), 32'(exp_v));
        check("err", 32'(err), 32'(exp_err));
        check("addr", 32'(addr), 32'(exp_addr));
        check("data", 32'(data), 32'(exp_data));
        rx_v = 1'b0;
    endtask

    task automatic send(input logic [7:0] b, input int gap);
        step(1'b1, b);
        for (int i = 0; i < gap; i++) step(1'b0, 8'h00);
    endtask

    task automatic send_frame(input logic [7:0] a, input logic [7:0] h,
                              input logic [7:0] l, input logic [7:0] c, input int gap);
        send(8'hA5, gap);
        send(a, gap);
        send(h, gap);
        send(l, gap);
        send(c, gap);
    endtask

    task automatic do_reset(input int cycles);
        rst_n = 1'b0;
        model_reset();
        #1;
        check("rst_addr", 32'(addr), 32'h0);
        check("rst_data", 32'(data), 32'h0);
        check("rst_v", 32'(data_v), 32'h0);
        check("rst_err", 32'(err), 32'h0);
        for (int i = 0; i < cycles; i++) step(1'b0, 8'h00);
        rst_n = 1'b1;
    endtask

    function automatic int rand_gap();
        int r;
        r = int'($urandom_range(0, 39));
        if (r == 0) return TMO;
        if (r == 1) return TMO - 1;
        return int'($urandom_range(0, 3));
    endfunction

    function automatic logic [7:0] rand_byte();
        if ($urandom_range(0, 7) == 0) return 8'hA5;
        return 8'($urandom());
    endfunction

    task automatic rand_frame();
        logic [7:0] a, h, l, c;
        int kind;
        kind = int'($urandom_range(0, 9));
        for (int i = 0; i < int'($urandom_range(0, 2)); i++) send(rand_byte(), rand_gap());
        a = rand_byte();
        h = rand_byte();
        l = rand_byte();
        c = a ^ h ^ l;
        if (kind < 2) c = c ^ 8'($urandom_range(1, 255));
        send(8'hA5, rand_gap());
        send(a, rand_gap());
        send(h, rand_gap());
        send(l, rand_gap());
        send(c, rand_gap());
    endtask

    initial begin
        rst_n = 1'b0;
        rx_v  = 1'b0;
        rx    = 8'h00;
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        check("init_addr", 32'(addr), 32'h0);
        check("init_data", 32'(data), 32'h0);
        check("init_v", 32'(data_v), 32'h0);
        check("init_err", 32'(err), 32'h0);
        rst_n = 1'b1;
        step(1'b0, 8'h00);

        // Good frame, strobes 10 cycles apart; then bad checksum keeps outputs.
        send_frame(8'h12, 8'h34, 8'h56, 8'h70, 9);
        send_frame(8'h12, 8'h34, 8'h56, 8'h71, 9);

        // Leading garbage, second A5 is payload.
        send(8'h00, 1);
        send(8'hFF, 1);
        send(8'hA5, 1);
        send(8'hA5, 1);
        send(8'h01, 1);
        send(8'h02, 1);
        send(8'hA6, 2);

        // Back-to-back frames at one byte per cycle.
        send_frame(8'h01, 8'h00, 8'h01, 8'h00, 0);
        send_frame(8'h02, 8'hFF, 8'hFF, 8'h02, 0);
        step(1'b0, 8'h00);

`ifdef UART_CMD_TIMEOUT_EN
        send(8'hA5, 0);
        send(8'h12, TMO);
        send_frame(8'h01, 8'h02, 8'h03, 8'h00, 0);
        send(8'hA5, 0);
        send(8'h12, TMO - 1);
        send(8'h34, 0);
        send(8'h56, 0);
        send(8'h77, 2);
`else
        // Without the timeout a long stall mid-frame must not abort.
        send(8'hA5, 0);
        send(8'h12, 150);
        send(8'h34, 0);
        send(8'h56, 0);
        send(8'h77, 2);
`endif

        // Reset mid-frame loses the partial frame and clears outputs.
        send(8'hA5, 0);
        send(8'h12, 0);
        send(8'h34, 0);
        do_reset(3);
        send(8'h56, 0);
        send(8'h70, 2);
        send_frame(8'h12, 8'h34, 8'h56, 8'h70, 1);

        for (int f = 0; f < 300; f++) begin
            rand_frame();
            if (f == 150) do_reset(int'($urandom_range(1, 3)));
        end
        repeat (3) step(1'b0, 8'h00);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

`default_nettype wire
